lifo_drain: RTL

Downstream drain stage for the `lifo` stack. On a start command, `lifo_drain` pops a programmed number of words, or pops until the stack is empty. It presents the words LIFO-order on a valid/ready stream with full backpressure. It owns the `lifo` pop port and hides the stack's one-cycle read latency from the consumer.

---
 rtl/lifo_pkg.sv | 18 +
 rtl/lifo_drain_skid.sv | 51 +++++
 rtl/lifo_drain.sv | 139 +++++++++++++
 3 files changed

// File: rtl/lifo_pkg.sv
// Shared types and defaults for the lifo stack and its neighbours (lifo_drain).
package lifo_pkg;

  localparam int LIFO_DATA_WIDTH = 8;
  localparam int LIFO_DEPTH      = 16;

  typedef enum logic [1:0] {
    DRAIN_IDLE  = 2'd0,
    DRAIN_POP   = 2'd1,
    DRAIN_FLUSH = 2'd2
  } lifo_drain_state_t;

  // Counter width able to hold 0..depth inclusive.
  function automatic int lifo_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lifo_drain_skid.sv
// Two-entry valid/ready buffer. The writer must never write while two entries
// are held without a same-cycle dequeue; occ is exported so it can enforce that.
module lifo_drain_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic [1:0]   occ,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic [1:0][W-1:0] mem_q, mem_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [1:0]        occ_q, occ_d;
  logic              deq;

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = mem_q[rd_q];
  assign occ       = occ_q;
  assign deq       = out_valid && out_ready;

  always_comb begin
    mem_d = mem_q;
    if (in_valid) begin
      mem_d[wr_q] = in_data;
    end
    wr_d  = wr_q ^ in_valid;
    rd_d  = rd_q ^ deq;
    occ_d = occ_q + {1'b0, in_valid} - {1'b0, deq};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      occ_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end

endmodule

// File: rtl/lifo_drain.sv
// Drain stage for the lifo stack: pops count words (0 = until empty) onto a
// valid/ready stream. Optional m_parity port with LIFO_DRAIN_PARITY_EN.
module lifo_drain
  import lifo_pkg::*;
#(
  parameter  int DATA_WIDTH = LIFO_DATA_WIDTH,
  parameter  int DEPTH      = LIFO_DEPTH,
  localparam int CW         = lifo_cw(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CW-1:0]         count,
  output logic                  busy,
  output logic                  done,
  output logic                  underrun,
  output logic                  lifo_pop,
  input  logic                  lifo_empty,
  input  logic [DATA_WIDTH-1:0] lifo_data_out,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
`ifdef LIFO_DRAIN_PARITY_EN
  output logic                  m_parity,
`endif
  input  logic                  m_ready
);

`ifdef LIFO_DRAIN_PARITY_EN
  localparam int SW = DATA_WIDTH + 1;
`else
  localparam int SW = DATA_WIDTH;
`endif

  lifo_drain_state_t state_q, state_d;
  logic [CW-1:0]     target_q, target_d;
  logic [CW-1:0]     issued_q, issued_d;
  logic              inflight_q, inflight_d;
  logic              pend_q, pend_d;
  logic              underrun_q, underrun_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic [1:0]        occ;
  logic [SW-1:0]     skid_in, skid_out;
  logic              deq;
  logic [2:0]        occ_sum;

`ifdef LIFO_DRAIN_PARITY_EN
  assign skid_in  = {^lifo_data_out, lifo_data_out};
  assign m_parity = skid_out[DATA_WIDTH];
`else
  assign skid_in  = lifo_data_out;
`endif
  assign m_data = skid_out[DATA_WIDTH-1:0];

  // The word popped last cycle arrives now, so the pop is registered as inflight.
  lifo_drain_skid #(.W(SW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inflight_q),
    .in_data   (skid_in),
    .occ       (occ),
    .out_valid (m_valid),
    .out_data  (skid_out),
    .out_ready (m_ready)
  );

  assign deq      = m_valid && m_ready;
  // Buffer occupancy after this edge, counting the word still in flight.
  assign occ_sum  = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, deq};
  assign lifo_pop = (state_q == DRAIN_POP) && !lifo_empty &&
                    ((issued_q != target_q) || (target_q == '0)) &&
                    (occ_sum < 3'd2);

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    issued_d   = issued_q + CW'(lifo_pop);
    inflight_d = lifo_pop;
    pend_d     = pend_q;
    underrun_d = underrun_q;
    done_d     = 1'b0;
    case (state_q)
      DRAIN_IDLE: begin
        if (start) begin
          target_d   = count;
          issued_d   = '0;
          pend_d     = 1'b0;
          underrun_d = 1'b0;
          state_d    = DRAIN_POP;
        end
      end
      DRAIN_POP: begin
        if (lifo_pop && (target_q != '0) && (issued_q + CW'(1) == target_q)) begin
          state_d = DRAIN_FLUSH;
        end else if (lifo_empty && !lifo_pop) begin
          state_d = DRAIN_FLUSH;
          pend_d  = (target_q != '0);
        end
      end
      DRAIN_FLUSH: ;
      default: state_d = DRAIN_IDLE;
    endcase
    // Look ahead so done lands in the first cycle the buffer is empty.
    if ((state_d == DRAIN_FLUSH) && !lifo_pop && (occ_sum == 3'd0)) begin
      state_d    = DRAIN_IDLE;
      done_d     = 1'b1;
      underrun_d = pend_d;
    end
    busy_d = (state_d != DRAIN_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DRAIN_IDLE;
      target_q   <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      pend_q     <= 1'b0;
      underrun_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      issued_q   <= issued_d;
      inflight_q <= inflight_d;
      pend_q     <= pend_d;
      underrun_q <= underrun_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = underrun_q;

endmodule
